rr_arb_stage: RTL and testbench



---
 rtl/rr_arb_stage.sv | 112 +++++++++++
 tb/tb_rr_arb_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_stage.sv
// N-input round-robin arbiter feeding a single registered output slot with one-hot grant.
// Optional ARB_LOCK_EN adds in_lock so one requester can hold the grant across beats.
module rr_arb_stage #(
    parameter int unsigned N     = 4,
    parameter int unsigned Nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*Nbits-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [Nbits-1:0]   out_data,
    output logic [N-1:0]       out_grant,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]       in_lock,
`endif
    input  logic               out_ready
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0]  ptr_q;
    logic [PtrW-1:0]  ptr_nxt;
    logic [PtrW-1:0]  win_idx;
    logic [N-1:0]     eligible;
    logic [N-1:0]     win;
    logic [Nbits-1:0] win_data;
    logic             found;
    logic             accept;
    logic             ptr_adv;

`ifdef ARB_LOCK_EN
    logic            lock_active_q;
    logic [PtrW-1:0] lock_owner_q;
    logic            lock_hit;
`endif

    assign accept = !out_valid || out_ready;

    always_comb begin
        int unsigned idx;
        eligible = in_valid;
`ifdef ARB_LOCK_EN
        if (lock_active_q) begin
            eligible = in_valid & (N'(1) << lock_owner_q);
        end
`endif
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        // Scan starting at ptr so the last winner ends up with lowest priority.
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = PtrW'(idx);
            end
        end
        win      = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (found && (32'(win_idx) == i)) begin
                win[i]   = 1'b1;
                win_data = in_data[i*Nbits +: Nbits];
            end
        end
        ptr_nxt = PtrW'((32'(win_idx) + 1) % N);
    end

`ifdef ARB_LOCK_EN
    assign lock_hit = |(win & in_lock);
    assign ptr_adv  = !lock_hit;
`else
    assign ptr_adv  = 1'b1;
`endif

    assign in_ready = (accept && !reset) ? win : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr_q     <= '0;
        end else if (accept) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_grant <= win;
                if (ptr_adv) begin
                    ptr_q <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else if (accept && found) begin
            lock_active_q <= lock_hit;
            lock_owner_q  <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_stage.sv
// Directed bench for rr_arb_stage (N=4): reset, fairness, stall, skip/wrap, idle drain, lock.
module tb_rr_arb_stage;

    localparam int unsigned N     = 4;
    localparam int unsigned Nbits = 32;

    logic               clk;
    logic               reset;
    logic [N-1:0]       in_valid;
    logic [N*Nbits-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [Nbits-1:0]   out_data;
    logic [N-1:0]       out_grant;
    logic               out_ready;
`ifdef ARB_LOCK_EN
    logic [N-1:0]       in_lock;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rr_arb_stage #(.N(N), .Nbits(Nbits)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
`ifdef ARB_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [N-1:0] g,
                           input logic [31:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".grant"}, 32'(out_grant), 32'(g));
        chk({tag, ".data"}, out_data, d);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i*Nbits +: Nbits] = 32'hA0 + i;
`ifdef ARB_LOCK_EN
        in_lock = '0;
`endif
        #2;
        chk_out("reset", 1'b0, 4'b0000, 32'h0);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rr.first_ready", 32'(in_ready), 32'b0001);

        // Fairness: all valid, one grant per cycle rotating 0,1,2,3,0.
        tick();
        chk_out("rr0", 1'b1, 4'b0001, 32'hA0);
        chk("rr0.in_ready", 32'(in_ready), 32'b0010);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("rr%0d", k), 1'b1, 4'(1 << (k % 4)), 32'hA0 + (k % 4));
        end

        // Stall: ptr=1, fill from ch2, hold 3 cycles, then drain+refill from ch3.
        in_valid = 4'b0100;
        #1;
        chk("stall.fill_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("stall.fill", 1'b1, 4'b0100, 32'hA2);
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        #1;
        chk("stall.ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("stall.hold%0d", k), 1'b1, 4'b0100, 32'hA2);
            chk($sformatf("stall.ready_hold%0d", k), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.refill_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("stall.refill", 1'b1, 4'b1000, 32'hA3);

        // Skip/wrap: ptr=0 -> ch2 sets ptr=3; only ch1 valid -> ch1 wins, ptr=2.
        in_valid = 4'b0100;
        tick();
        chk_out("wrap.ch2", 1'b1, 4'b0100, 32'hA2);
        in_valid = 4'b0010;
        #1;
        chk("wrap.skip_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("wrap.ch1", 1'b1, 4'b0010, 32'hA1);
        in_valid = 4'b0110;
        #1;
        chk("wrap.ptr2_ready", 32'(in_ready), 32'b0100);
        in_valid = 4'b1000;
        #1;
        chk("wrap.ch3_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("wrap.ch3", 1'b1, 4'b1000, 32'hA3);

        // Idle drain: no requests, slot empties but data/grant hold.
        in_valid = 4'b0000;
        tick();
        chk_out("idle.drain", 1'b0, 4'b1000, 32'hA3);
        tick();
        chk_out("idle.hold", 1'b0, 4'b1000, 32'hA3);
        in_valid = 4'b1111;
        #1;
        chk("idle.ptr0_ready", 32'(in_ready), 32'b0001);

        // Reset mid-stall discards the held beat and ptr.
        out_ready = 1'b0;
        tick();
        chk_out("rst.fill", 1'b1, 4'b0001, 32'hA0);
        tick();
        chk_out("rst.stall", 1'b1, 4'b0001, 32'hA0);
        #3;
        reset = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 4'b0000, 32'h0);
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst.post_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("rst.post", 1'b1, 4'b0001, 32'hA0);

`ifdef ARB_LOCK_EN
        // ptr=1: ch1 locks for two beats, gap of two cycles, then unlocks.
        in_valid = 4'b0111;
        in_lock  = 4'b0010;
        #1;
        chk("lock.b1_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("lock.b1", 1'b1, 4'b0010, 32'hA1);
        chk("lock.b2_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("lock.b2", 1'b1, 4'b0010, 32'hA1);
        in_valid = 4'b0101;
        #1;
        chk("lock.gap0_ready", 32'(in_ready), 32'h0);
        tick();
        chk("lock.gap0_valid", 32'(out_valid), 32'h0);
        chk("lock.gap1_ready", 32'(in_ready), 32'h0);
        tick();
        in_valid = 4'b0111;
        in_lock  = 4'b0000;
        #1;
        chk("lock.b3_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("lock.b3", 1'b1, 4'b0010, 32'hA1);
        chk("lock.after_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("lock.after", 1'b1, 4'b0100, 32'hA2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
